// File: rtl/pll_lock_freq_monitor.sv
// PLL lock / frequency monitor: watches pll_lock for drops after first lock and, once lock has
// settled, counts rising edges of each PLL output over a fixed window against an expected count.
module pll_lock_freq_monitor #(
    parameter int NUM_CH        = 5,
    parameter int CNT_W         = 16,
    parameter int WIN_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 256,
    parameter int TOL           = 2,
    parameter int SYNC_STAGES   = 3,
    parameter int ERR_CNT_W     = 3
) (
    input  logic                    clk_tb,
    input  logic                    rst_n,
    input  logic                    chk_en,
    input  logic                    pll_lock,
    input  logic [NUM_CH-1:0]       clk_meas,
    input  logic [NUM_CH*CNT_W-1:0] exp_cnt,
    output logic [NUM_CH*CNT_W-1:0] meas_cnt,
    output logic                    meas_valid,
    output logic [NUM_CH-1:0]       err_vec,
    output logic                    lock_err,
    output logic                    err_chk,
    output logic [3:0]              lock_pulse_cnt,
    output logic [ERR_CNT_W-1:0]    results_cnt,
    output logic [2:0]              state
);

    localparam int WIN_W = $clog2(WIN_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        MEASURE   = 3'd3,
        COMPARE   = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0]    r_lock_sync;
    logic [SYNC_STAGES-1:0]    r_clk_sync [NUM_CH];
    logic [CNT_W-1:0]          r_cnt      [NUM_CH];
    logic [CNT_W-1:0]          w_cnt_inc  [NUM_CH];
    logic [NUM_CH-1:0]         w_edge;
    logic [NUM_CH-1:0]         w_err;
    logic [NUM_CH*CNT_W-1:0]   r_exp;
    logic [NUM_CH*CNT_W-1:0]   r_meas_cnt;
    logic [NUM_CH-1:0]         r_err_vec;
    logic                      r_meas_valid;
    logic                      r_lock_err;
    logic                      r_err_chk;
    logic [3:0]                r_lock_pulse_cnt;
    logic [ERR_CNT_W-1:0]      r_results_cnt;
    logic [WIN_W-1:0]          r_win_tmr;
    logic [SET_W-1:0]          r_settle_tmr;

    logic w_lock_s, w_lock_rise, w_lock_fall;
    logic w_active, w_lock_drop, w_lock_evt, w_win_end, w_load_exp;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != {CNT_W{1'b1}}))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    // Signed difference one bit wider than the counters so any pair of counts is representable.
    function automatic logic out_of_tol(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] expv);
        logic signed [CNT_W:0] diff;
        logic        [CNT_W:0] mag;
        diff = $signed({1'b0, cnt}) - $signed({1'b0, expv});
        mag  = diff[CNT_W] ? -diff : diff;
        return mag > (CNT_W+1)'(TOL);
    endfunction

    assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
    assign w_lock_rise = ~r_lock_sync[SYNC_STAGES-1] &  r_lock_sync[SYNC_STAGES-2];
    assign w_lock_fall =  r_lock_sync[SYNC_STAGES-1] & ~r_lock_sync[SYNC_STAGES-2];
    assign w_active    = (r_state == SETTLE) || (r_state == MEASURE) || (r_state == COMPARE);
    assign w_lock_drop = w_active & w_lock_fall;
    assign w_lock_evt  = w_lock_drop & (r_lock_pulse_cnt != 4'd0);

    always_comb begin
        w_edge = '0;
        w_err  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_edge[i]    = ~r_clk_sync[i][SYNC_STAGES-1] & r_clk_sync[i][SYNC_STAGES-2];
            w_cnt_inc[i] = sat_inc(r_cnt[i], w_edge[i]);
            w_err[i]     = out_of_tol(w_cnt_inc[i], r_exp[i*CNT_W +: CNT_W]);
        end
    end

    // Next-state: enable loss dominates, then lock loss, then normal sequencing.
    always_comb begin
        w_state_nxt = r_state;
        if (!chk_en) begin
            w_state_nxt = IDLE;
        end else if (w_lock_drop) begin
            w_state_nxt = WAIT_LOCK;
        end else begin
            case (r_state)
                IDLE:      w_state_nxt = WAIT_LOCK;
                WAIT_LOCK: if (w_lock_s) w_state_nxt = SETTLE;
                SETTLE:    if (r_settle_tmr == SET_W'(SETTLE_CYCLES - 1)) w_state_nxt = MEASURE;
                MEASURE:   if (r_win_tmr == WIN_W'(WIN_CYCLES - 1)) w_state_nxt = COMPARE;
                COMPARE:   w_state_nxt = MEASURE;
                default:   w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_win_end  = (r_state == MEASURE) && (w_state_nxt == COMPARE);
    assign w_load_exp = (w_state_nxt == MEASURE) && (r_state != MEASURE);

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lock_sync <= '0;
            for (int i = 0; i < NUM_CH; i++) r_clk_sync[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_lock};
            for (int i = 0; i < NUM_CH; i++)
                r_clk_sync[i] <= {r_clk_sync[i][SYNC_STAGES-2:0], clk_meas[i]};
        end
    end

    // Window counters only run in MEASURE; any other state (incl. COMPARE) discards edges.
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
            r_win_tmr    <= '0;
            r_settle_tmr <= '0;
            r_exp        <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                r_cnt[i] <= (r_state == MEASURE) ? w_cnt_inc[i] : '0;
            r_win_tmr    <= (r_state == MEASURE) ? r_win_tmr + WIN_W'(1) : '0;
            r_settle_tmr <= (r_state == SETTLE) ? r_settle_tmr + SET_W'(1) : '0;
            if (w_load_exp)
                r_exp <= exp_cnt;
        end
    end

    // Results are captured on the last window cycle so they are already valid during COMPARE.
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            r_meas_cnt       <= '0;
            r_err_vec        <= '0;
            r_meas_valid     <= 1'b0;
            r_lock_err       <= 1'b0;
            r_err_chk        <= 1'b0;
            r_lock_pulse_cnt <= '0;
            r_results_cnt    <= '0;
        end else begin
            r_meas_valid <= w_win_end;
            if (w_win_end) begin
                for (int i = 0; i < NUM_CH; i++)
                    r_meas_cnt[i*CNT_W +: CNT_W] <= w_cnt_inc[i];
                r_err_vec <= w_err;
            end
            r_err_chk  <= ((r_state == COMPARE) && (|r_err_vec)) || w_lock_evt;
            r_lock_err <= r_lock_err | w_lock_evt;
            if (r_err_chk && (r_results_cnt != {ERR_CNT_W{1'b1}}))
                r_results_cnt <= r_results_cnt + ERR_CNT_W'(1);
            if (w_lock_rise && (r_lock_pulse_cnt != 4'hF))
                r_lock_pulse_cnt <= r_lock_pulse_cnt + 4'd1;
        end
    end

    assign meas_cnt       = r_meas_cnt;
    assign meas_valid     = r_meas_valid;
    assign err_vec        = r_err_vec;
    assign lock_err       = r_lock_err;
    assign err_chk        = r_err_chk;
    assign lock_pulse_cnt = r_lock_pulse_cnt;
    assign results_cnt    = r_results_cnt;
    assign state          = r_state;

endmodule

// File: tb/tb_pll_lock_freq_monitor.sv
// Scoreboard bench for pll_lock_freq_monitor: PLL outputs are derived from clk_tb with periods
// dividing the window length, so every window holds an exact, phase-independent edge count.
`timescale 1ns/1ps
module tb_pll_lock_freq_monitor;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 16;
    localparam int WIN    = 1000;
    localparam int SETTLE = 256;
    localparam int TOLV   = 2;
    localparam int VW     = NUM_CH * CNT_W;

    logic             clk_tb = 1'b0;
    logic             rst_n, chk_en, pll_lock;
    logic [NUM_CH-1:0] clk_meas = '0;
    logic [VW-1:0]    exp_cnt;
    logic [VW-1:0]    meas_cnt;
    logic             meas_valid, lock_err, err_chk;
    logic [NUM_CH-1:0] err_vec;
    logic [3:0]       lock_pulse_cnt;
    logic [2:0]       results_cnt;
    logic [2:0]       state;

    pll_lock_freq_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SETTLE),
        .TOL(TOLV), .SYNC_STAGES(3), .ERR_CNT_W(3)
    ) dut (
        .clk_tb(clk_tb), .rst_n(rst_n), .chk_en(chk_en), .pll_lock(pll_lock),
        .clk_meas(clk_meas), .exp_cnt(exp_cnt), .meas_cnt(meas_cnt), .meas_valid(meas_valid),
        .err_vec(err_vec), .lock_err(lock_err), .err_chk(err_chk),
        .lock_pulse_cnt(lock_pulse_cnt), .results_cnt(results_cnt), .state(state)
    );

    always #1 clk_tb = ~clk_tb;

    // Periods in clk_tb cycles: 40ns (25MHz), 20ns (50MHz), 16ns, 80ns, 8ns.
    function automatic int per(input int i);
        case (i)
            0: return 20;
            1: return 10;
            2: return 8;
            3: return 40;
            default: return 4;
        endcase
    endfunction

    int tick = 0;
    always @(negedge clk_tb) begin
        for (int i = 0; i < NUM_CH; i++) clk_meas[i] <= ((tick % per(i)) < (per(i) / 2));
        tick <= tick + 1;
    end

    typedef struct packed {
        logic [VW-1:0]     meas;
        logic [NUM_CH-1:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_errchk = 0;
    int   errchk_seen = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        else
            n_pass++;
    endtask

    function automatic logic [VW-1:0] mk_exp(input int e0, e1, e2, e3, e4);
        logic [VW-1:0] v;
        v = {CNT_W'(e4), CNT_W'(e3), CNT_W'(e2), CNT_W'(e1), CNT_W'(e0)};
        return v;
    endfunction

    function automatic logic [VW-1:0] model_cnt();
        logic [VW-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(WIN / per(i));
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_err(input logic [VW-1:0] e);
        logic [NUM_CH-1:0] r;
        int d;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            d = (WIN / per(i)) - int'(e[i*CNT_W +: CNT_W]);
            r[i] = (d > TOLV) || (d < -TOLV);
        end
        return r;
    endfunction

    logic [NUM_CH-1:0] last_err = '0;

    task automatic push_win(input logic [VW-1:0] e);
        exp_t x;
        x.meas = model_cnt();
        x.err  = model_err(e);
        sb_q.push_back(x);
        if (|x.err) exp_errchk++;
        last_err = x.err;
    endtask

    task automatic wait_valid(input int bound, output int lat);
        lat = 0;
        do begin
            @(negedge clk_tb);
            lat++;
        end while (!meas_valid && lat < bound);
        if (!meas_valid) check("meas_valid_timeout", meas_valid, 1'b1);
    endtask

    // Monitor: pop on every meas_valid and check err_chk one cycle later.
    initial begin
        exp_t e;
        logic pend = 1'b0;
        logic pend_val = 1'b0;
        forever begin
            @(negedge clk_tb);
            if (err_chk) errchk_seen++;
            if (pend) begin
                check("err_chk_after_valid", err_chk, pend_val);
                pend = 1'b0;
            end
            if (meas_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_meas_valid", meas_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("meas_cnt", meas_cnt, e.meas);
                    check("err_vec", err_vec, e.err);
                    pend     = 1'b1;
                    pend_val = |e.err;
                end
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] e_nom, e_tol_a, e_tol_b, e_ch1;
        int lat;
        e_nom   = mk_exp(50, 100, 125, 25, 250);
        e_tol_a = mk_exp(48, 100, 127, 22, 253);
        e_tol_b = mk_exp(47, 100, 125, 25, 250);
        e_ch1   = mk_exp(50, 50, 125, 25, 250);

        rst_n = 1'b0; chk_en = 1'b0; pll_lock = 1'b0; exp_cnt = e_nom;
        repeat (3) @(negedge clk_tb);
        check("rst_state", state, 3'd0);
        check("rst_meas_cnt", meas_cnt, '0);
        check("rst_meas_valid", meas_valid, 1'b0);
        check("rst_err_vec", err_vec, '0);
        check("rst_lock_err", lock_err, 1'b0);
        check("rst_err_chk", err_chk, 1'b0);
        check("rst_lock_pulse_cnt", lock_pulse_cnt, 4'd0);
        check("rst_results_cnt", results_cnt, 3'd0);
        rst_n = 1'b1;
        @(negedge clk_tb);
        chk_en = 1'b1; pll_lock = 1'b1;

        // Nominal window, all channels on target
        push_win(e_nom);
        wait_valid(3000, lat);
        check("lock_pulse_cnt_first", lock_pulse_cnt, 4'd1);
        check("results_cnt_clean", results_cnt, 3'd0);

        // Tolerance boundaries: +/-TOL passes, +/-(TOL+1) fails
        exp_cnt = e_tol_a; push_win(e_tol_a); wait_valid(1100, lat);
        exp_cnt = e_tol_b; push_win(e_tol_b); wait_valid(1100, lat);

        // Persistent ch1 error until results_cnt saturates
        exp_cnt = e_ch1;
        for (int w = 0; w < 6; w++) begin
            push_win(e_ch1);
            wait_valid(1100, lat);
        end

        // Lock drop mid-window; this window must not report
        exp_cnt = e_nom;
        repeat (300) @(negedge clk_tb);
        check("results_cnt_sat", results_cnt, 3'd7);
        check("err_chk_pulses_windows", errchk_seen, exp_errchk);
        pll_lock = 1'b0;
        exp_errchk++;
        repeat (50) @(negedge clk_tb);
        check("state_wait_lock", state, 3'd1);
        check("lock_err_sticky", lock_err, 1'b1);
        check("meas_cnt_hold_lockdrop", meas_cnt, model_cnt());
        check("err_vec_hold_lockdrop", err_vec, last_err);
        pll_lock = 1'b1;
        push_win(e_nom);
        wait_valid(2000, lat);
        check("lock_pulse_cnt_relock", lock_pulse_cnt, 4'd2);
        check("lock_err_still_set", lock_err, 1'b1);

        // chk_en low mid-window, then re-enable with lock held
        repeat (300) @(negedge clk_tb);
        check("err_chk_pulses_lockdrop", errchk_seen, exp_errchk);
        chk_en = 1'b0;
        @(negedge clk_tb);
        check("state_idle", state, 3'd0);
        repeat (20) @(negedge clk_tb);
        check("state_idle_hold", state, 3'd0);
        check("err_vec_hold_disable", err_vec, last_err);
        chk_en = 1'b1;
        push_win(e_nom);
        wait_valid(3000, lat);
        check("reenable_latency", lat, SETTLE + WIN + 2);

        // Asynchronous reset mid-window
        repeat (300) @(negedge clk_tb);
        #0.5 rst_n = 1'b0;
        #0.1;
        check("arst_state", state, 3'd0);
        check("arst_meas_cnt", meas_cnt, '0);
        check("arst_err_vec", err_vec, '0);
        check("arst_lock_err", lock_err, 1'b0);
        check("arst_lock_pulse_cnt", lock_pulse_cnt, 4'd0);
        check("arst_results_cnt", results_cnt, 3'd0);
        @(negedge clk_tb);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_tb);
        check("lock_pulse_recount", lock_pulse_cnt, 4'd1);
        check("state_settle_after_rst", state, 3'd2);
        chk_en = 1'b0;
        repeat (3) @(negedge clk_tb);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
